// File: rtl/pcie_pkg.sv
// Shared PCIe TX types: the per-lane-group buffer record and virtual-channel indexing.
package pcie_pkg;

    localparam int TX_VC_MAX = 8;

    // One record carries four lanes worth of symbols plus their control-symbol flags.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  k;
    } tx_buffer_record;

    typedef logic [$clog2(TX_VC_MAX)-1:0] vc_idx_t;

endpackage

// File: rtl/tx_vc_fifo.sv
// Single virtual-channel circular FIFO with occupancy count, synchronous flush
// and a registered almost-full flag.
module tx_vc_fifo
    import pcie_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int RECS      = 1,
    parameter  int AF_MARGIN = 1,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr_en,
    input  tx_buffer_record [0:RECS-1]  i_wr_data,
    input  logic                        i_rd_en,
    input  logic                        i_flush,
    output tx_buffer_record [0:RECS-1]  o_rd_data,
    output logic                        o_not_full,
    output logic                        o_not_empty,
    output logic                        o_af,
    output logic [CW-1:0]               o_cnt_nxt
);

    logic [PW-1:0]              wr_ptr_r;
    logic [PW-1:0]              rd_ptr_r;
    logic [PW-1:0]              wr_ptr_nxt_s;
    logic [PW-1:0]              rd_ptr_nxt_s;
    logic [CW-1:0]              cnt_r;
    logic [CW-1:0]              cnt_nxt_s;
    logic                       af_r;
    logic                       wr_ok_s;
    logic                       rd_ok_s;
    tx_buffer_record [0:RECS-1] mem_r [DEPTH];

    assign o_not_full  = (cnt_r != CW'(DEPTH));
    assign o_not_empty = (cnt_r != CW'(0));
    // A flush wins over any same-cycle write or pop on this channel.
    assign wr_ok_s     = i_wr_en && o_not_full && !i_flush;
    assign rd_ok_s     = i_rd_en && o_not_empty && !i_flush;
    assign o_rd_data   = mem_r[rd_ptr_r];
    assign o_af        = af_r;
    assign o_cnt_nxt   = cnt_nxt_s;

    // Next-state pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        cnt_nxt_s    = cnt_r;
        if (i_flush) begin
            wr_ptr_nxt_s = PW'(0);
            rd_ptr_nxt_s = PW'(0);
            cnt_nxt_s    = CW'(0);
        end else begin
            if (wr_ok_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_ok_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   cnt_nxt_s = cnt_r + CW'(1);
                2'b01:   cnt_nxt_s = cnt_r - CW'(1);
                default: cnt_nxt_s = cnt_r;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            cnt_r    <= CW'(0);
            af_r     <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            cnt_r    <= cnt_nxt_s;
            af_r     <= (cnt_nxt_s >= CW'(DEPTH - AF_MARGIN));
        end
    end

    // Payload storage, intentionally left unreset.
    always_ff @(posedge i_clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= i_wr_data;
        end
    end

endmodule

// File: rtl/tx_vc_buffer.sv
// Multi-VC TX buffer: per-VC FIFOs drained round-robin into one registered valid/ready port.
// Define TX_VC_BUF_ERR_EN to build the sticky {underflow, overflow} error flags on o_err.
module tx_vc_buffer
    import pcie_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int NUM_LANES = 4,
    parameter  int NUM_VC    = 2,
    parameter  int AF_MARGIN = 1,
    localparam int VCW       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int RECS      = NUM_LANES / 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr_valid,
    input  logic [VCW-1:0]              i_wr_vc,
    input  tx_buffer_record [0:RECS-1]  i_wr_data,
    output logic [NUM_VC-1:0]           o_wr_ready,
    output logic [NUM_VC-1:0]           o_throttle,
    input  logic [NUM_VC-1:0]           i_flush,
    output logic                        o_rd_valid,
    output logic [VCW-1:0]              o_rd_vc,
    output tx_buffer_record [0:RECS-1]  o_rd_data,
    input  logic                        i_rd_ready,
    output logic                        o_empty,
    output logic [1:0]                  o_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [NUM_VC-1:0]          vc_sel_s;
    logic [NUM_VC-1:0]          wr_en_s;
    logic [NUM_VC-1:0]          rd_en_s;
    logic [NUM_VC-1:0]          not_empty_s;
    logic [NUM_VC-1:0]          elig_s;
    tx_buffer_record [0:RECS-1] fifo_data_s [NUM_VC];
    logic [CW-1:0]              cnt_nxt_s [NUM_VC];

    logic [VCW-1:0]             rr_ptr_r;
    logic [VCW-1:0]             scan_idx_s;
    logic [VCW-1:0]             grant_vc_s;
    logic                       grant_found_s;
    logic                       load_s;
    logic                       fifos_empty_nxt_s;
    logic                       rd_valid_nxt_s;

    logic                       rd_valid_r;
    logic [VCW-1:0]             rd_vc_r;
    tx_buffer_record [0:RECS-1] rd_data_r;
    logic                       empty_r;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign vc_sel_s[v] = (i_wr_vc == VCW'(v));
        assign wr_en_s[v]  = i_wr_valid && vc_sel_s[v];
        assign rd_en_s[v]  = load_s && (grant_vc_s == VCW'(v));

        tx_vc_fifo #(
            .DEPTH     (DEPTH),
            .RECS      (RECS),
            .AF_MARGIN (AF_MARGIN)
        ) u_fifo (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_wr_en     (wr_en_s[v]),
            .i_wr_data   (i_wr_data),
            .i_rd_en     (rd_en_s[v]),
            .i_flush     (i_flush[v]),
            .o_rd_data   (fifo_data_s[v]),
            .o_not_full  (o_wr_ready[v]),
            .o_not_empty (not_empty_s[v]),
            .o_af        (o_throttle[v]),
            .o_cnt_nxt   (cnt_nxt_s[v])
        );
    end

    // A channel being flushed this cycle is not offered to the arbiter.
    assign elig_s = not_empty_s & ~i_flush;
    assign load_s = (!rd_valid_r || i_rd_ready) && grant_found_s;

    // Round-robin scan starting just after the last granted channel.
    always_comb begin
        grant_found_s = 1'b0;
        grant_vc_s    = rr_ptr_r;
        scan_idx_s    = rr_ptr_r;
        for (int k = 1; k <= NUM_VC; k++) begin
            scan_idx_s = VCW'((int'(rr_ptr_r) + k) % NUM_VC);
            if (!grant_found_s && elig_s[scan_idx_s]) begin
                grant_found_s = 1'b1;
                grant_vc_s    = scan_idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Look-ahead of the emptiness of every FIFO and of the output register.
    always_comb begin
        fifos_empty_nxt_s = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            if (cnt_nxt_s[v] != CW'(0)) begin
                fifos_empty_nxt_s = 1'b0;
            end else begin
                fifos_empty_nxt_s = fifos_empty_nxt_s;
            end
        end
        rd_valid_nxt_s = load_s || (rd_valid_r && !i_rd_ready);
    end

    // Output register, arbiter pointer and registered empty flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid_r <= 1'b0;
            rd_vc_r    <= VCW'(0);
            rd_data_r  <= '0;
            rr_ptr_r   <= VCW'(0);
            empty_r    <= 1'b1;
        end else begin
            empty_r <= fifos_empty_nxt_s && !rd_valid_nxt_s;
            if (load_s) begin
                rd_valid_r <= 1'b1;
                rd_vc_r    <= grant_vc_s;
                rd_data_r  <= fifo_data_s[grant_vc_s];
                rr_ptr_r   <= grant_vc_s;
            end else if (i_rd_ready) begin
                rd_valid_r <= 1'b0;
            end
        end
    end

    assign o_rd_valid = rd_valid_r;
    assign o_rd_vc    = rd_vc_r;
    assign o_rd_data  = rd_data_r;
    assign o_empty    = empty_r;

`ifdef TX_VC_BUF_ERR_EN
    logic       wr_full_s;
    logic       rd_under_s;
    logic [1:0] err_r;

    assign wr_full_s  = i_wr_valid && |(vc_sel_s & ~o_wr_ready);
    assign rd_under_s = i_rd_ready && !rd_valid_r && !(|not_empty_s);

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_r <= 2'b00;
        end else begin
            if (wr_full_s) begin
                err_r[0] <= 1'b1;
            end
            if (rd_under_s) begin
                err_r[1] <= 1'b1;
            end
        end
    end

    assign o_err = err_r;
`else
    assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_tx_vc_buffer.sv
// Randomized and directed bench for tx_vc_buffer against a queue-based reference model.
module tb_tx_vc_buffer;
    import pcie_pkg::*;

    localparam int DEPTH     = 4;
    localparam int NUM_LANES = 4;
    localparam int NUM_VC    = 2;
    localparam int AF_MARGIN = 1;
    localparam int VCW       = 1;
    localparam int RECS      = NUM_LANES / 4;
    localparam int DW        = $bits(tx_buffer_record) * RECS;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       wr_valid;
    logic [VCW-1:0]             wr_vc;
    tx_buffer_record [0:RECS-1] wr_data;
    logic [NUM_VC-1:0]          wr_ready;
    logic [NUM_VC-1:0]          throttle;
    logic [NUM_VC-1:0]          flush;
    logic                       rd_valid;
    logic [VCW-1:0]             rd_vc;
    tx_buffer_record [0:RECS-1] rd_data;
    logic                       rd_ready;
    logic                       empty;
    logic [1:0]                 err;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DW-1:0]     mq [NUM_VC][$];
    logic              m_valid;
    int                m_vc;
    logic [DW-1:0]     m_data;
    int                m_rr;
    logic [1:0]        m_err;
    logic [NUM_VC-1:0] m_thr;

    tx_vc_buffer #(
        .DEPTH     (DEPTH),
        .NUM_LANES (NUM_LANES),
        .NUM_VC    (NUM_VC),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_valid (wr_valid),
        .i_wr_vc    (wr_vc),
        .i_wr_data  (wr_data),
        .o_wr_ready (wr_ready),
        .o_throttle (throttle),
        .i_flush    (flush),
        .o_rd_valid (rd_valid),
        .o_rd_vc    (rd_vc),
        .o_rd_data  (rd_data),
        .i_rd_ready (rd_ready),
        .o_empty    (empty),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_all_empty();
        for (int v = 0; v < NUM_VC; v++) begin
            if (mq[v].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NUM_VC; v++) mq[v].delete();
        m_valid = 1'b0;
        m_vc    = 0;
        m_data  = '0;
        m_rr    = 0;
        m_err   = 2'b00;
        m_thr   = '0;
    endtask

    task automatic model_step();
        int  g;
        bit  wr_ok;
        int  wv;
        wv    = int'(wr_vc);
        wr_ok = wr_valid && (wv < NUM_VC) && (mq[wv].size() < DEPTH) && !flush[wv];
        if (wr_valid && (wv < NUM_VC) && (mq[wv].size() == DEPTH)) m_err[0] = 1'b1;
        if (rd_ready && !m_valid && m_all_empty()) m_err[1] = 1'b1;
        if (!m_valid || rd_ready) begin
            g = -1;
            for (int k = 1; k <= NUM_VC; k++) begin
                int c;
                c = (m_rr + k) % NUM_VC;
                if (g < 0 && mq[c].size() > 0 && !flush[c]) g = c;
            end
            if (g >= 0) begin
                m_data  = mq[g].pop_front();
                m_vc    = g;
                m_rr    = g;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (wr_ok) mq[wv].push_back(DW'(wr_data));
        for (int v = 0; v < NUM_VC; v++) if (flush[v]) mq[v].delete();
        for (int v = 0; v < NUM_VC; v++) m_thr[v] = (mq[v].size() >= DEPTH - AF_MARGIN);
    endtask

    task automatic check_all();
        logic [NUM_VC-1:0] exp_rdy;
        logic [1:0]        exp_err;
        for (int v = 0; v < NUM_VC; v++) exp_rdy[v] = (mq[v].size() < DEPTH);
`ifdef TX_VC_BUF_ERR_EN
        exp_err = m_err;
`else
        exp_err = 2'b00;
`endif
        chk("wr_ready", 64'(wr_ready), 64'(exp_rdy));
        chk("throttle", 64'(throttle), 64'(m_thr));
        chk("rd_valid", 64'(rd_valid), 64'(m_valid));
        chk("rd_vc",    64'(rd_vc),    64'(m_vc));
        chk("rd_data",  64'(rd_data),  64'(m_data));
        chk("empty",    64'(empty),    64'(!m_valid && m_all_empty()));
        chk("err",      64'(err),      64'(exp_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input int vc, input logic [DW-1:0] d,
                         input logic rr, input logic [NUM_VC-1:0] fl);
        wr_valid = v;
        wr_vc    = VCW'(vc);
        wr_data  = d;
        rd_ready = rr;
        flush    = fl;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, 0, '0, rr, '0);
    endtask

    initial begin
        logic [DW-1:0] exp_seq [4];
        rst_n = 1'b0;
        idle(1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_ready", 64'(wr_ready), 64'h3);
        chk("rst_thr",   64'(throttle), 64'd0);
        check_all();
        rst_n = 1'b1;

        // Latency: write at N, output valid after the next edge, then held.
        drive(1'b1, 0, 36'h0_A000_0001, 1'b0, '0);
        cycle();
        chk("lat_no_bypass", 64'(rd_valid), 64'd0);
        idle(1'b0);
        cycle();
        chk("lat_valid", 64'(rd_valid), 64'd1);
        chk("lat_data",  64'(rd_data),  64'h0_A000_0001);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_data", 64'(rd_data), 64'h0_A000_0001);
        end
        idle(1'b1);
        cycle();
        chk("consumed", 64'(rd_valid), 64'd0);

        // Fill VC0 behind an occupied output register.
        drive(1'b1, 1, 36'h1_0000_00FF, 1'b0, '0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 0, DW'(36'h2_0000_0000 + i), 1'b0, '0);
            cycle();
            if (i == 1) chk("thr_after2", 64'(throttle[0]), 64'd0);
            if (i == 2) chk("thr_after3", 64'(throttle[0]), 64'd1);
            if (i == 3) chk("rdy_after4", 64'(wr_ready[0]), 64'd0);
        end
        chk("rdy_after5", 64'(wr_ready[0]), 64'd0);
`ifdef TX_VC_BUF_ERR_EN
        chk("err_ovf", 64'(err[0]), 64'd1);
`endif
        idle(1'b1);
        repeat (8) cycle();
        chk("drained_empty", 64'(empty), 64'd1);

        // Round-robin order A,C,B,D.
        exp_seq[0] = 36'h0_0000_000A; exp_seq[1] = 36'h0_0000_000C;
        exp_seq[2] = 36'h0_0000_000B; exp_seq[3] = 36'h0_0000_000D;
        drive(1'b1, 0, exp_seq[0], 1'b0, '0); cycle();
        drive(1'b1, 0, exp_seq[2], 1'b0, '0); cycle();
        drive(1'b1, 1, exp_seq[1], 1'b0, '0); cycle();
        drive(1'b1, 1, exp_seq[3], 1'b0, '0); cycle();
        idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", 64'(rd_data), 64'(exp_seq[i]));
            cycle();
        end
        chk("rr_done", 64'(rd_valid), 64'd0);

        // Same-VC write and pop with VC1 holding two entries.
        drive(1'b1, 1, 36'h0_0000_00E0, 1'b0, '0); cycle();
        drive(1'b1, 1, 36'h0_0000_00E1, 1'b0, '0); cycle();
        drive(1'b1, 1, 36'h0_0000_00E2, 1'b0, '0); cycle();
        drive(1'b1, 1, 36'h0_0000_00E3, 1'b1, '0); cycle();
        chk("wp_data", 64'(rd_data), 64'h0_0000_00E1);
        chk("wp_thr",  64'(throttle[1]), 64'd0);
        idle(1'b1);
        cycle(); chk("wp_next", 64'(rd_data), 64'h0_0000_00E2);
        cycle(); chk("wp_last", 64'(rd_data), 64'h0_0000_00E3);
        cycle();

        // Flush VC0 with three entries plus a same-cycle write.
        drive(1'b1, 1, 36'h0_0000_0F00, 1'b0, '0); cycle();
        drive(1'b1, 1, 36'h0_0000_0F01, 1'b0, '0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, DW'(36'h0_0000_0E00 + i), 1'b0, '0);
            cycle();
        end
        chk("fl_thr_pre", 64'(throttle[0]), 64'd1);
        drive(1'b1, 0, 36'h0_0000_0EFF, 1'b0, 2'b01);
        cycle();
        chk("fl_thr_post", 64'(throttle[0]), 64'd0);
        chk("fl_data_kept", 64'(rd_data), 64'h0_0000_0F00);
        idle(1'b1);
        cycle(); chk("fl_vc1", 64'(rd_data), 64'h0_0000_0F01);
        cycle(); chk("fl_gone", 64'(rd_valid), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, NUM_VC - 1)),
                  {4'($urandom), 32'($urandom)}, ($urandom_range(0, 9) < 5),
                  {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)});
            cycle();
        end

        // Asynchronous reset mid-stream.
        drive(1'b1, 0, 36'h0_0000_0555, 1'b0, '0);
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(rd_valid), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_err",   64'(err), 64'd0);
        model_reset();
        idle(1'b0);
        cycle();
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 9) < 6), int'($urandom_range(0, NUM_VC - 1)),
                  {4'($urandom), 32'($urandom)}, ($urandom_range(0, 9) < 6),
                  {($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0)});
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
